// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared types, encodings and default parameters for the
//                pong game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // FSM state encoding, also presented on the game_state output
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  // Winner encoding
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Default game parameters
  localparam int DEFAULT_WIN_SCORE    = 7;
  localparam int DEFAULT_SERVE_FRAMES = 60;
  localparam int DEFAULT_MOVE_DIV     = 1;

  // Score increment that sticks at the 4-bit maximum
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect
//  Description : Registers a level input and produces a one-cycle pulse on
//                its rising (RISING=1) or falling (RISING=0) edge. The pulse
//                is derived purely from registers, so it carries no
//                combinational path from the input pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect #(
  parameter bit RISING    = 1'b1,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic cur;
  logic prev;

  // Two-stage sample of the input; reset value chosen so no edge is seen on release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur  <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      cur  <= din;
      prev <= cur;
    end
  end

  generate
    if (RISING) begin : g_rise
      assign pulse = cur & ~prev;
    end else begin : g_fall
      assign pulse = ~cur & prev;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pong_game_ctrl
//  Description : Pong match controller: frame pacing from vsync, serve delay,
//                move-step divider, scoring and win detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int SERVE_FRAMES = DEFAULT_SERVE_FRAMES,
  parameter int MOVE_DIV     = DEFAULT_MOVE_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       start,
  input  logic       pause,
  input  logic       ball_out_left,
  input  logic       ball_out_right,
  output logic       move_enable,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [2:0] game_state,
  output logic [1:0] winner
);

  localparam logic [3:0] WIN_SCORE_4 = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST  = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] MOVE_LAST   = 4'(MOVE_DIV - 1);

  game_state_t state;
  game_state_t state_next;
  logic        frame_tick;
  logic        start_ev;
  logic [7:0]  serve_cnt;
  logic [3:0]  div_cnt;
  logic        scorer_p2;
  logic [3:0]  scorer_score;
  logic        enter_serve;
  logic        live_tick;

  // vsync idles high, so its detector resets high to require a real 1->0
  edge_detect #(.RISING(1'b0), .RESET_VAL(1'b1)) u_vsync_fall (
    .clk   (clk),
    .rst   (rst),
    .din   (vsync),
    .pulse (frame_tick)
  );

  edge_detect #(.RISING(1'b1), .RESET_VAL(1'b0)) u_start_rise (
    .clk   (clk),
    .rst   (rst),
    .din   (start),
    .pulse (start_ev)
  );

  assign live_tick    = frame_tick & ~pause;
  assign scorer_score = scorer_p2 ? p2_score : p1_score;
  assign enter_serve  = (state_next == SERVE) && (state != SERVE);
  assign game_state   = state;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the combinational move_enable strobe
  always_comb begin
    state_next  = state;
    move_enable = 1'b0;
    case (state)
      IDLE: begin
        if (start_ev) state_next = SERVE;
      end
      SERVE: begin
        if (live_tick && (serve_cnt == SERVE_LAST)) state_next = PLAY;
      end
      PLAY: begin
        move_enable = live_tick && (div_cnt == MOVE_LAST);
        // Left has priority but both lead to POINT either way
        if (ball_out_left || ball_out_right) state_next = POINT;
      end
      POINT: begin
        state_next = (scorer_score == WIN_SCORE_4) ? GAME_OVER : SERVE;
      end
      GAME_OVER: begin
        if (start_ev) state_next = SERVE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, scores, serve direction, winner and the ball_reset pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serve_cnt  <= 8'd0;
      div_cnt    <= 4'd0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      winner     <= WINNER_NONE;
      serve_dir  <= 1'b1;
      ball_reset <= 1'b0;
      scorer_p2  <= 1'b0;
    end else begin
      // Registered so it lands in the first cycle the state reads SERVE
      ball_reset <= enter_serve;

      if (enter_serve) begin
        serve_cnt <= 8'd0;
      end else if ((state == SERVE) && live_tick) begin
        serve_cnt <= serve_cnt + 8'd1;
      end

      // Divider idles at zero outside PLAY so each rally starts fresh
      if (state != PLAY) begin
        div_cnt <= 4'd0;
      end else if (live_tick) begin
        div_cnt <= (div_cnt == MOVE_LAST) ? 4'd0 : div_cnt + 4'd1;
      end

      if (((state == IDLE) || (state == GAME_OVER)) && start_ev) begin
        p1_score  <= 4'd0;
        p2_score  <= 4'd0;
        winner    <= WINNER_NONE;
        serve_dir <= 1'b1;
      end

      if (state == PLAY) begin
        if (ball_out_left) begin
          p2_score  <= sat_inc(p2_score);
          serve_dir <= 1'b0;
          scorer_p2 <= 1'b1;
        end else if (ball_out_right) begin
          p1_score  <= sat_inc(p1_score);
          serve_dir <= 1'b1;
          scorer_p2 <= 1'b0;
        end
      end

      if ((state == POINT) && (scorer_score == WIN_SCORE_4)) begin
        winner <= scorer_p2 ? WINNER_P2 : WINNER_P1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_game_ctrl
//  Description : Scoreboard bench for pong_game_ctrl (WIN_SCORE=3,
//                SERVE_FRAMES=2, MOVE_DIV=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int K_ST = 0;  // change of {state, scores, winner, serve_dir}
  localparam int K_BR = 1;  // ball_reset pulse
  localparam int K_ME = 2;  // move_enable pulse at a given cycle

  typedef struct {
    int         kind;
    logic [2:0] st;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] w;
    logic       d;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       start;
  logic       pause;
  logic       ball_out_left;
  logic       ball_out_right;
  logic       move_enable;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [2:0] game_state;
  logic [1:0] winner;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  pong_game_ctrl #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (2),
    .MOVE_DIV     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .vsync          (vsync),
    .start          (start),
    .pause          (pause),
    .ball_out_left  (ball_out_left),
    .ball_out_right (ball_out_right),
    .move_enable    (move_enable),
    .ball_reset     (ball_reset),
    .serve_dir      (serve_dir),
    .p1_score       (p1_score),
    .p2_score       (p2_score),
    .game_state     (game_state),
    .winner         (winner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_st(input game_state_t s, input int p1, input int p2,
                        input logic [1:0] w, input logic d);
    exp_t e;
    e.kind = K_ST; e.st = s; e.p1 = 4'(p1); e.p2 = 4'(p2);
    e.w = w; e.d = d; e.cyc = 0;
    q.push_back(e);
  endtask

  task automatic exp_ev(input int kind, input int c);
    exp_t e;
    e.kind = kind; e.st = 3'd0; e.p1 = 4'd0; e.p2 = 4'd0;
    e.w = 2'd0; e.d = 1'b0; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input string what);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got event expected none (cycle %0d)", what, cyc);
      return;
    end
    e = q.pop_front();
    chk({"kind_", what}, kind, e.kind);
    if (kind != e.kind) return;
    if (kind == K_ST) begin
      chk("game_state", int'(game_state), int'(e.st));
      chk("p1_score", int'(p1_score), int'(e.p1));
      chk("p2_score", int'(p2_score), int'(e.p2));
      chk("winner", int'(winner), int'(e.w));
      chk("serve_dir", int'(serve_dir), int'(e.d));
    end else if (kind == K_ME) begin
      chk("move_enable_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT shows an observable event
  initial begin : monitor
    logic [13:0] cur;
    logic [13:0] prev;
    bit          first;
    first = 1'b1;
    prev  = 14'd0;
    forever begin
      @(posedge clk);
      #1;
      cur = {game_state, p1_score, p2_score, winner, serve_dir};
      if (first || (cur != prev)) pop_cmp(K_ST, "state");
      if (ball_reset)  pop_cmp(K_BR, "ball_reset");
      if (move_enable) pop_cmp(K_ME, "move_enable");
      prev  = cur;
      first = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // One vsync low pulse; optionally expect move_enable on the tick cycle
  task automatic frame(input bit me);
    @(negedge clk);
    vsync = 1'b0;
    if (me) exp_ev(K_ME, cyc + 1);
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic outs(input logic l, input logic r);
    @(negedge clk);
    ball_out_left  = l;
    ball_out_right = r;
    @(negedge clk);
    ball_out_left  = 1'b0;
    ball_out_right = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic serve_to_play(input int p1, input int p2, input logic d);
    frame(1'b0);
    exp_st(PLAY, p1, p2, WINNER_NONE, d);
    frame(1'b0);
  endtask

  // Directed stimulus
  initial begin : stim
    rst = 1'b0; vsync = 1'b1; start = 1'b0; pause = 1'b0;
    ball_out_left = 1'b0; ball_out_right = 1'b0;
    exp_st(IDLE, 0, 0, WINNER_NONE, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Ball-out in IDLE is ignored
    outs(1'b1, 1'b0);
    outs(1'b0, 1'b1);

    // Held start gives one event and one ball_reset
    exp_st(SERVE, 0, 0, WINNER_NONE, 1'b1);
    exp_ev(K_BR, 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Ball-out in SERVE is ignored
    outs(1'b1, 1'b1);
    serve_to_play(0, 0, 1'b1);

    // MOVE_DIV=2: every second tick steps, then pause freezes stepping
    for (int i = 0; i < 3; i++) begin
      frame(1'b0);
      frame(1'b1);
    end
    pause = 1'b1;
    frame(1'b0);
    frame(1'b0);
    pause = 1'b0;

    // Simultaneous ball-out: left wins
    exp_st(POINT, 0, 1, WINNER_NONE, 1'b0);
    exp_st(SERVE, 0, 1, WINNER_NONE, 1'b0);
    exp_ev(K_BR, 0);
    outs(1'b1, 1'b1);
    serve_to_play(0, 1, 1'b0);

    // P1 scores three points and wins
    for (int k = 1; k <= 3; k++) begin
      exp_st(POINT, k, 1, WINNER_NONE, 1'b1);
      if (k < 3) begin
        exp_st(SERVE, k, 1, WINNER_NONE, 1'b1);
        exp_ev(K_BR, 0);
        outs(1'b0, 1'b1);
        serve_to_play(k, 1, 1'b1);
      end else begin
        exp_st(GAME_OVER, 3, 1, WINNER_P1, 1'b1);
        outs(1'b0, 1'b1);
      end
    end

    // GAME_OVER: no move steps, ball-out ignored
    frame(1'b0);
    outs(1'b1, 1'b0);
    outs(1'b0, 1'b1);

    // Restart clears scores and winner
    exp_st(SERVE, 0, 0, WINNER_NONE, 1'b1);
    exp_ev(K_BR, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    outs(1'b1, 1'b0);
    serve_to_play(0, 0, 1'b1);

    for (int k = 1; k <= 2; k++) begin
      exp_st(POINT, k, 0, WINNER_NONE, 1'b1);
      exp_st(SERVE, k, 0, WINNER_NONE, 1'b1);
      exp_ev(K_BR, 0);
      outs(1'b0, 1'b1);
      serve_to_play(k, 0, 1'b1);
    end

    // Asynchronous reset mid-game: immediate IDLE, no pulse on release
    @(negedge clk);
    exp_st(IDLE, 0, 0, WINNER_NONE, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_reset_state", int'(game_state), int'(IDLE));
    chk("async_reset_p1", int'(p1_score), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    outs(1'b0, 1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win the match; legal range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 60, frame ticks held in SERVE before play resumes; legal range 1..255.
REQ-003 Parameter MOVE_DIV, default 1, frame ticks per move_enable pulse in PLAY; legal range 1..15.
REQ-004 clk  input  1  100 MHz system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 vsync  input  1  VGA vertical sync from the timing generator, clk domain, active-low pulse.
REQ-007 start  input  1  start/serve button level, clk domain, debounced upstream.
REQ-008 pause  input  1  pause switch level; 1 = frozen.
REQ-009 ball_out_left  input  1  one-cycle pulse: ball passed the left (P1) edge.
REQ-010 ball_out_right  input  1  one-cycle pulse: ball passed the right (P2) edge.
REQ-011 move_enable  output  1  one-cycle pulse permitting one ball/paddle move step.
REQ-012 ball_reset  output  1  one-cycle pulse: centre the ball.
REQ-013 serve_dir  output  1  initial ball direction; 0 = toward P1 (left), 1 = toward P2 (right).
REQ-014 p1_score, p2_score  output  4 each  current scores.
REQ-015 game_state  output  3  current FSM state encoding.
REQ-016 winner  output  2  00 none, 01 P1, 10 P2.

Function
REQ-017 Frame tick: one-cycle internal pulse, the cycle after vsync is sampled 1 and then 0 (registered falling edge).
REQ-018 Start event: one-cycle pulse on a 0->1 transition of registered start; a held start yields one event.
REQ-019 States: IDLE, SERVE, PLAY, POINT, GAME_OVER.
REQ-020 IDLE: start event -> SERVE; scores cleared to 0, serve_dir = 1.
REQ-021 SERVE: ball_reset pulses in the first cycle of entry; the serve counter clears on entry and increments on each frame tick while pause = 0; when it reaches SERVE_FRAMES -> PLAY.
REQ-022 PLAY: a move divider counts frame ticks while pause = 0; move_enable pulses on the same cycle as the frame tick that completes MOVE_DIV ticks, then the divider clears.
REQ-023 PLAY: ball_out_left -> P2 gains a point, serve_dir = 0; ball_out_right -> P1 gains a point, serve_dir = 1; either -> POINT next cycle.
REQ-024 PLAY: if both ball_out pulses occur in the same cycle, ball_out_left wins and ball_out_right is ignored.
REQ-025 PLAY: ball_out pulses are honoured even while pause = 1.
REQ-026 POINT (one cycle): if the scorer's score equals WIN_SCORE -> GAME_OVER with winner set; otherwise -> SERVE.
REQ-027 GAME_OVER: move_enable = 0; scores and winner held; start event -> SERVE with scores cleared, winner = 00, serve_dir = 1.
REQ-028 move_enable is 0 in every state except PLAY.
REQ-029 ball_out pulses are ignored outside PLAY.
REQ-030 Start events are ignored in SERVE, PLAY and POINT.
REQ-031 Scores saturate at 15; with legal WIN_SCORE, saturation is unreachable.
REQ-032 All outputs are registered, except move_enable, which is combinational from state, pause and the registered frame tick (no further latency).

Reset
REQ-033 While rst = 0: state = IDLE; all counters = 0; edge-detect registers = 1 for vsync and 0 for start; move_enable = 0, ball_reset = 0, serve_dir = 1, scores = 0, winner = 00.
REQ-034 A reset asserted mid-game aborts immediately; no pulses are generated on release.
REQ-035 The first frame tick after reset release requires an observed vsync 1->0 transition.

Structure
REQ-036 Package pong_pkg holds: game_state_t enum (IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4), the winner encoding constants, and the WIN_SCORE/SERVE_FRAMES/MOVE_DIV defaults.
REQ-037 One sub-module, edge_detect (parameterised rise/fall), is instantiated twice: vsync falling edge and start rising edge.

Verification
REQ-038 Reset, start high 3 cycles, SERVE_FRAMES=2 -> one ball_reset pulse; PLAY entered after the 2nd frame tick; exactly one start event.
REQ-039 In PLAY, MOVE_DIV=2, 6 vsync falling edges -> exactly 3 move_enable pulses, each coincident with a frame tick; pause = 1 for 2 more edges -> 0 pulses.
REQ-040 ball_out_left and ball_out_right in the same cycle -> p2_score +1, p1_score unchanged, serve_dir = 0, SERVE after POINT.
REQ-041 WIN_SCORE=3, P1 scores 3 -> GAME_OVER, winner = 01, move_enable = 0; start -> SERVE, scores = 0, winner = 00.
REQ-042 rst pulled low during PLAY with p1_score = 2 -> same-cycle IDLE, scores = 0, no ball_reset pulse on release.
REQ-043 ball_out pulses in IDLE, SERVE and GAME_OVER -> scores unchanged.
